// File: rtl/uart_tx_if.sv
// Byte handshake and serial-line bundle between a byte producer and uart_tx.
interface uart_tx_if;
  logic       tx_valid;
  logic [7:0] data_in;
  logic       tx_ready;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  modport master (
    output tx_valid, data_in,
    input  tx_ready, tx, tx_busy, tx_done
  );

  modport slave (
    input  tx_valid, data_in,
    output tx_ready, tx, tx_busy, tx_done
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: 1-deep holding register feeding an 8N/E/O + 1/2-stop frame FSM.
// Assumes at least two clocks per bit (freq/baud_rate >= 2).
module uart_tx #(
  parameter int freq      = 100_000_000,
  parameter int baud_rate = 9600,
  parameter int parity    = 0,
  parameter int stop_bits = 1
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave bus
);

  localparam int BIT = freq / baud_rate;
  localparam int CW  = $clog2(BIT + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(BIT - 1);
  localparam logic [CW-1:0] CNT_PRE   = CW'(BIT - 2);
  localparam logic [2:0]    STOP_LAST = 3'(stop_bits - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic          hold_full;
  logic [7:0]    hold_data;
  logic [7:0]    shift;
  logic          par_bit;
  logic          tx_r;
  logic          busy_r;
  logic          done_r;

  logic bit_end;
  logic stop_end;
  logic load;
  logic accept;

  function automatic logic parity_of(input logic [7:0] d);
    return (^d) ^ (parity == 2);
  endfunction

  assign bit_end  = (cnt == CNT_LAST);
  assign stop_end = (state == STOP) && bit_end && (idx == STOP_LAST);
  assign load     = hold_full && ((state == IDLE) || stop_end);
  assign accept   = bus.tx_valid && !hold_full;

  assign bus.tx_ready = ~hold_full;
  assign bus.tx       = tx_r;
  assign bus.tx_busy  = busy_r;
  assign bus.tx_done  = done_r;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      hold_full <= 1'b0;
      tx_r      <= 1'b1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (accept)
        hold_full <= 1'b1;
      else if (load)
        hold_full <= 1'b0;

      // A full holding register at IDLE or at the end of STOP starts the next frame at once.
      if (load) begin
        state  <= START;
        tx_r   <= 1'b0;
        busy_r <= 1'b1;
        cnt    <= '0;
        idx    <= '0;
      end else begin
        case (state)
          IDLE: begin
            tx_r   <= 1'b1;
            busy_r <= 1'b0;
          end
          START: begin
            if (bit_end) begin
              state <= DATA;
              tx_r  <= shift[0];
              cnt   <= '0;
              idx   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          DATA: begin
            if (bit_end) begin
              cnt <= '0;
              if (idx == 3'd7) begin
                idx <= '0;
                if (parity != 0) begin
                  state <= PARITY;
                  tx_r  <= par_bit;
                end else begin
                  state <= STOP;
                  tx_r  <= 1'b1;
                end
              end else begin
                idx  <= idx + 1'b1;
                tx_r <= shift[1];
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          PARITY: begin
            if (bit_end) begin
              state <= STOP;
              tx_r  <= 1'b1;
              cnt   <= '0;
              idx   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          STOP: begin
            if (bit_end) begin
              cnt <= '0;
              if (idx == STOP_LAST) begin
                state  <= IDLE;
                tx_r   <= 1'b1;
                busy_r <= 1'b0;
              end else begin
                idx <= idx + 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
              // Raise done one clock early so it is registered on the final stop clock.
              if ((cnt == CNT_PRE) && (idx == STOP_LAST))
                done_r <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept)
      hold_data <= bus.data_in;
    if (load) begin
      shift   <= hold_data;
      par_bit <= parity_of(hold_data);
    end else if ((state == DATA) && bit_end) begin
      shift <= shift >> 1;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four configurations checked every cycle against a frame-timeline model.
module tb_uart_tx;

  localparam int BIT = 10;

  logic       clk;
  logic       rst;
  logic       valid [4];
  logic [7:0] din   [4];
  logic       tx_o  [4];
  logic       busy_o[4];
  logic       done_o[4];
  logic       ready_o[4];

  int n_tests;
  int n_fail;
  bit chk_en;

  uart_tx_if b0 ();
  uart_tx_if b1 ();
  uart_tx_if b2 ();
  uart_tx_if b3 ();

  uart_tx #(.freq(1_000_000), .baud_rate(100_000), .parity(0), .stop_bits(1))
    u0 (.clk(clk), .rst(rst), .bus(b0));
  uart_tx #(.freq(1_000_000), .baud_rate(100_000), .parity(1), .stop_bits(1))
    u1 (.clk(clk), .rst(rst), .bus(b1));
  uart_tx #(.freq(1_000_000), .baud_rate(100_000), .parity(2), .stop_bits(1))
    u2 (.clk(clk), .rst(rst), .bus(b2));
  uart_tx #(.freq(1_000_000), .baud_rate(100_000), .parity(0), .stop_bits(2))
    u3 (.clk(clk), .rst(rst), .bus(b3));

  assign b0.tx_valid = valid[0];
  assign b1.tx_valid = valid[1];
  assign b2.tx_valid = valid[2];
  assign b3.tx_valid = valid[3];
  assign b0.data_in  = din[0];
  assign b1.data_in  = din[1];
  assign b2.data_in  = din[2];
  assign b3.data_in  = din[3];
  assign tx_o[0] = b0.tx;       assign tx_o[1] = b1.tx;
  assign tx_o[2] = b2.tx;       assign tx_o[3] = b3.tx;
  assign busy_o[0] = b0.tx_busy; assign busy_o[1] = b1.tx_busy;
  assign busy_o[2] = b2.tx_busy; assign busy_o[3] = b3.tx_busy;
  assign done_o[0] = b0.tx_done; assign done_o[1] = b1.tx_done;
  assign done_o[2] = b2.tx_done; assign done_o[3] = b3.tx_done;
  assign ready_o[0] = b0.tx_ready; assign ready_o[1] = b1.tx_ready;
  assign ready_o[2] = b2.tx_ready; assign ready_o[3] = b3.tx_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pcfg(input int i);
    return (i == 1) ? 1 : (i == 2) ? 2 : 0;
  endfunction

  function automatic int scfg(input int i);
    return (i == 3) ? 2 : 1;
  endfunction

  function automatic int flen(input int i);
    return (10 + ((pcfg(i) != 0) ? 1 : 0) + scfg(i) - 1) * BIT;
  endfunction

  // Line bits in transmit order: start, d0..d7, optional parity, then stop ones.
  function automatic logic [11:0] frame_of(input int i, input logic [7:0] d);
    logic [11:0] f;
    f = 12'hFFF;
    f[0] = 1'b0;
    f[8:1] = d;
    if (pcfg(i) != 0) f[9] = (^d) ^ (pcfg(i) == 2);
    return f;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: holding register plus a frame position counter per transmitter.
  bit          m_full [4];
  logic [7:0]  m_hold [4];
  bit          m_act  [4];
  int          m_pos  [4];
  logic [11:0] m_frame[4];
  logic        e_tx   [4];
  logic        e_busy [4];
  logic        e_done [4];
  logic        e_ready[4];

  initial begin
    forever begin
      @(posedge clk);
      for (int i = 0; i < 4; i++) begin
        if (!rst) begin
          m_full[i] = 1'b0;
          m_act[i]  = 1'b0;
          m_pos[i]  = 0;
        end else begin
          if (m_act[i]) begin
            m_pos[i]++;
            if (m_pos[i] == flen(i)) m_act[i] = 1'b0;
          end
          if (!m_act[i] && m_full[i]) begin
            m_frame[i] = frame_of(i, m_hold[i]);
            m_act[i]   = 1'b1;
            m_pos[i]   = 0;
            m_full[i]  = 1'b0;
          end else if (valid[i] && !m_full[i]) begin
            m_hold[i] = din[i];
            m_full[i] = 1'b1;
          end
        end
        e_tx[i]    = m_act[i] ? m_frame[i][m_pos[i] / BIT] : 1'b1;
        e_busy[i]  = m_act[i];
        e_done[i]  = m_act[i] && (m_pos[i] == flen(i) - 1);
        e_ready[i] = !m_full[i];
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int i = 0; i < 4; i++) begin
          check($sformatf("u%0d.tx", i),       tx_o[i],    e_tx[i]);
          check($sformatf("u%0d.tx_busy", i),  busy_o[i],  e_busy[i]);
          check($sformatf("u%0d.tx_done", i),  done_o[i],  e_done[i]);
          check($sformatf("u%0d.tx_ready", i), ready_o[i], e_ready[i]);
        end
      end
    end
  end

  logic lb[0:255];
  logic bb[0:255];
  logic db[0:255];
  logic rb[0:255];

  task automatic capture(input int i, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      lb[k] = tx_o[i];
      bb[k] = busy_o[i];
      db[k] = done_o[i];
      rb[k] = ready_o[i];
    end
  endtask

  task automatic send(input int i, input logic [7:0] b);
    int w;
    w = 0;
    @(negedge clk);
    while (!ready_o[i] && w < 500) begin
      @(negedge clk);
      w++;
    end
    check("send_ready_wait", (w < 500) ? 1 : 0, 1);
    valid[i] = 1'b1;
    din[i]   = b;
    @(negedge clk);
    valid[i] = 1'b0;
  endtask

  function automatic int cnt_lb(input int lo, input int hi);
    int c = 0;
    for (int k = lo; k <= hi; k++) if (lb[k]) c++;
    return c;
  endfunction

  function automatic int cnt_bb(input int lo, input int hi);
    int c = 0;
    for (int k = lo; k <= hi; k++) if (bb[k]) c++;
    return c;
  endfunction

  function automatic int cnt_db(input int lo, input int hi);
    int c = 0;
    for (int k = lo; k <= hi; k++) if (db[k]) c++;
    return c;
  endfunction

  function automatic int first_done(input int n);
    for (int k = 0; k < n; k++) if (db[k]) return k;
    return -1;
  endfunction

  // Receiver: samples the middle of each data bit of a frame starting at offset o.
  function automatic logic [7:0] decode(input int o);
    logic [7:0] d;
    for (int j = 0; j < 8; j++) d[j] = lb[o + (1 + j) * BIT + BIT / 2];
    return d;
  endfunction

  logic [9:0] line;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    chk_en  = 1'b0;
    rst     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      valid[i] = 1'b0;
      din[i]   = 8'h00;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("reset_tx", tx_o[0], 1);
    check("reset_ready", ready_o[0], 1);
    check("reset_busy", busy_o[0], 0);
    check("reset_done", done_o[0], 0);
    rst = 1'b1;

    // Idle line after reset
    capture(0, 100);
    check("idle_tx_high", cnt_lb(0, 99), 100);
    check("idle_busy", cnt_bb(0, 99), 0);

    // Single frame 0x99, no parity
    send(0, 8'h99);
    capture(0, 110);
    for (int k = 0; k < 10; k++) line[k] = lb[k * BIT + 5];
    check("h99_line", line, 10'b1100110010);
    check("h99_done_pos", first_done(110), 99);
    check("h99_done_cnt", cnt_db(0, 109), 1);
    check("h99_busy_len", cnt_bb(0, 109), 100);

    // Back-to-back: 0xA5 offered while 0x99 is pending
    @(negedge clk);
    valid[0] = 1'b1;
    din[0]   = 8'h99;
    @(negedge clk);
    check("b2b_ready_low", ready_o[0], 0);
    din[0] = 8'hA5;
    fork
      begin
        @(negedge clk);
        @(negedge clk);
        valid[0] = 1'b0;
      end
    join_none
    capture(0, 210);
    check("b2b_ready_back", rb[0], 1);
    check("b2b_byte1", decode(0), 8'h99);
    check("b2b_byte2", decode(100), 8'hA5);
    check("b2b_stop_to_start", {lb[99], lb[100]}, 2'b10);
    check("b2b_busy_no_gap", cnt_bb(0, 199), 200);
    check("b2b_done_cnt", cnt_db(0, 209), 2);
    check("b2b_idle_after", bb[205], 0);

    // Even and odd parity with 0x07
    send(1, 8'h07);
    capture(1, 120);
    check("even_par_bit", lb[95], 1);
    check("even_done_pos", first_done(120), 109);
    check("even_byte", decode(0), 8'h07);
    send(2, 8'h07);
    capture(2, 120);
    check("odd_par_bit", lb[95], 0);
    check("odd_done_pos", first_done(120), 109);

    // Reset mid-frame with a byte pending
    send(0, 8'h55);
    send(0, 8'hC3);
    check("abort_pending", ready_o[0], 0);
    capture(0, 43);
    check("abort_no_done", cnt_db(0, 42), 0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("abort_tx", tx_o[0], 1);
    check("abort_ready", ready_o[0], 1);
    check("abort_busy", busy_o[0], 0);
    check("abort_done", done_o[0], 0);
    capture(0, 40);
    check("abort_line_idle", cnt_lb(0, 39), 40);
    check("abort_discarded", cnt_bb(0, 39), 0);
    send(0, 8'h3C);
    capture(0, 110);
    check("after_abort_byte", decode(0), 8'h3C);
    check("after_abort_done", first_done(110), 99);

    // Two stop bits with 0xFF
    send(3, 8'hFF);
    capture(3, 120);
    check("stop2_start", lb[5], 0);
    check("stop2_high", cnt_lb(90, 109), 20);
    check("stop2_done_pos", first_done(120), 109);
    check("stop2_loopback", decode(0), 8'hFF);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

endmodule
